// File: rtl/local_maxima_collector.sv
// rtl/local_maxima_collector.sv - buffers flagged pixels of a raster frame and drains them as peak entries
// Optional feature macro: COLLECTOR_THRESHOLD_EN (peaks must also reach MIN_PEAK)
module local_maxima_collector #(
  parameter int WIDTH      = 6,
  parameter int HEIGHT     = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_PEAK   = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [7:0]                         in_pixel,
  input  logic                               in_flag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(HEIGHT)-1:0]          out_row,
  output logic [$clog2(WIDTH)-1:0]           out_col,
  output logic [7:0]                         out_value,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]  peak_count,
  output logic                               overflow,
  output logic                               frame_done
);

  localparam int RW  = $clog2(HEIGHT);
  localparam int CW  = $clog2(WIDTH);
  localparam int PCW = $clog2(WIDTH*HEIGHT+1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = RW + CW + 8;

`ifdef COLLECTOR_THRESHOLD_EN
  localparam bit THRESH_ON = 1'b1;
`else
  localparam bit THRESH_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t         state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    fill;
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [EW-1:0]  head;

  logic fifo_empty;
  logic fifo_full;
  logic xfer;
  logic is_peak;
  logic pop;
  logic push;
  logic drop;
  logic first_pixel;
  logic last_pixel;
  logic drain_exit;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Handshake decode: input readiness depends on state alone.
  assign in_ready   = (state == S_COLLECT);
  assign frame_done = (state == S_DONE);
  assign xfer       = in_valid && in_ready;

  // With the threshold disabled every flagged pixel qualifies.
  assign is_peak    = in_flag && (!THRESH_ON || (in_pixel >= 8'(MIN_PEAK)));

  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;

  // A full FIFO still accepts a peak when the head leaves in the same cycle.
  assign push       = xfer && is_peak && (!fifo_full || pop);
  assign drop       = xfer && is_peak && fifo_full && !pop;

  assign first_pixel = (row == '0) && (col == '0);
  assign last_pixel  = (row == RW'(HEIGHT-1)) && (col == CW'(WIDTH-1));

  // Drain finishes once the FIFO is empty, or becomes empty with this pop.
  assign drain_exit  = fifo_empty || ((fill == (AW+1)'(1)) && pop);

  // Show-ahead head; forced to zero while nothing is queued so reset values are defined.
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_value = out_valid ? head[7:0]          : '0;
  assign out_col   = out_valid ? head[CW+7:8]       : '0;
  assign out_row   = out_valid ? head[EW-1:CW+8]    : '0;

  // Frame sequencing and raster position tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_COLLECT;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (xfer) begin
            if (col == CW'(WIDTH-1)) begin
              col <= '0;
              row <= (row == RW'(HEIGHT-1)) ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_pixel) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          row   <= '0;
          col   <= '0;
          state <= S_COLLECT;
        end
        default: begin
          state <= S_COLLECT;
        end
      endcase
    end
  end

  // FIFO pointer advance on accepted push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {row, col, in_pixel};
    end
  end

  // Per-frame peak statistics; restart on the first pixel of each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_count <= '0;
      overflow   <= 1'b0;
    end else if (xfer) begin
      if (first_pixel) begin
        peak_count <= is_peak ? PCW'(1) : '0;
        overflow   <= drop;
      end else begin
        if (is_peak) begin
          peak_count <= peak_count + PCW'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
